// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle fetch/decode/execute sequencer that drives a 16-bit ALU and register file.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC). Each cycle spent waiting for i_imem_ack adds one cycle.
// Backpressure: o_imem_req and o_pc stay stable until i_imem_ack. There are no other stall points.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start leaves IDLE;
//    o_pc/o_imem_req/i_imem_ack/i_instr instruction fetch handshake;
//    o_alu_control, o_ra_addr/o_rb_addr/o_rd_addr, o_sel_imm, o_imm, o_reg_we datapath control;
//    i_mayor/i_paridad/i_zero ALU flags in; o_flags latched {mayor, paridad, zero}; o_halted HALT indicator.
module alu_control_unit #(
   parameter int N    = 16,
   parameter int PC_W = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   output logic [PC_W-1:0] o_pc,
   output logic            o_imem_req,
   input  logic            i_imem_ack,
   input  logic [N-1:0]    i_instr,
   output logic [2:0]      o_alu_control,
   output logic [3:0]      o_ra_addr,
   output logic [3:0]      o_rb_addr,
   output logic [3:0]      o_rd_addr,
   output logic            o_sel_imm,
   output logic [N-1:0]    o_imm,
   output logic            o_reg_we,
   input  logic            i_mayor,
   input  logic            i_paridad,
   input  logic            i_zero,
   output logic [2:0]      o_flags,
   output logic            o_halted
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_JC   = 4'h9;
   localparam logic [3:0] OP_JN   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b010;
   localparam logic [2:0] ALU_SHR    = 3'b001;
   localparam logic [2:0] ALU_SHL    = 3'b011;
   localparam logic [2:0] ALU_PASS_B = 3'b100;
   localparam logic [2:0] ALU_PASS_A = 3'b101;

   // Non-ALU opcodes leave the ALU on pass_a, which is also the reset code.
   function automatic logic [2:0] alu_code(input logic [3:0] op);
      case (op)
         4'h0:    alu_code = ALU_ADD;
         4'h1:    alu_code = ALU_SUB;
         4'h2:    alu_code = ALU_SHR;
         4'h3:    alu_code = ALU_SHL;
         4'h4:    alu_code = ALU_PASS_B;
         4'h5:    alu_code = ALU_PASS_A;
         4'h6:    alu_code = ALU_PASS_B;
         default: alu_code = ALU_PASS_A;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [N-1:0]    ir_q, ir_d;
   logic [2:0]      flags_q, flags_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [2:0]      alu_q, alu_d;
   logic            sel_imm_q, sel_imm_d;
   logic            halted_q, halted_d;

   logic [3:0]      exec_op;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] target;

   assign exec_op = ir_q[15:12];
   assign pc_inc  = pc_q + PC_W'(1);   // wraps modulo 2^PC_W
   assign target  = ir_q[PC_W-1:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      flags_d   = flags_q;
      req_d     = req_q;
      we_d      = 1'b0;                 // the write strobe lasts exactly one cycle (EXEC)
      alu_d     = alu_q;
      sel_imm_d = sel_imm_q;
      halted_d  = halted_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
            end
         end
         S_FETCH: begin
            if (i_imem_ack) begin
               // The ALU code and sel_imm are registered from the incoming word.
               // This lets them be valid in DECODE together with the IR-derived fields.
               ir_d      = i_instr;
               alu_d     = alu_code(i_instr[15:12]);
               sel_imm_d = (i_instr[15:12] == OP_LDI);
               req_d     = 1'b0;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            we_d    = (exec_op <= OP_LDI);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            case (exec_op)
               OP_JMP:  pc_d = target;
               OP_JZ:   pc_d = flags_q[0] ? target : pc_inc;
               OP_JC:   pc_d = flags_q[2] ? target : pc_inc;
               OP_JN:   pc_d = flags_q[1] ? target : pc_inc;
               OP_HALT: begin
                  state_d  = S_HALT;
                  req_d    = 1'b0;
                  halted_d = 1'b1;
               end
               default: begin
                  pc_d = pc_inc;
                  // Only ALU ops update flags. NOPs (B..E) leave them untouched.
                  if (exec_op <= OP_LDI) begin
                     flags_d = {i_mayor, i_paridad, i_zero};
                  end
               end
            endcase
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         flags_q   <= 3'b000;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         alu_q     <= ALU_PASS_A;
         sel_imm_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         req_q     <= req_d;
         we_q      <= we_d;
         alu_q     <= alu_d;
         sel_imm_q <= sel_imm_d;
         halted_q  <= halted_d;
      end
   end

   assign o_pc          = pc_q;
   assign o_imem_req    = req_q;
   assign o_reg_we      = we_q;
   assign o_alu_control = alu_q;
   assign o_sel_imm     = sel_imm_q;
   assign o_flags       = flags_q;
   assign o_halted      = halted_q;
   // The register fields decode straight from IR, which is zero after reset.
   assign o_rd_addr     = ir_q[11:8];
   assign o_ra_addr     = ir_q[7:4];
   assign o_rb_addr     = ir_q[3:0];
   assign o_imm         = {{(N-8){1'b0}}, ir_q[7:0]};

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;
   localparam int N    = 16;
   localparam int PC_W = 8;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_start = 1'b0;
   logic            i_imem_ack = 1'b0;
   logic [N-1:0]    i_instr = '0;
   logic            i_mayor = 1'b0;
   logic            i_paridad = 1'b0;
   logic            i_zero = 1'b0;
   logic [PC_W-1:0] o_pc;
   logic            o_imem_req;
   logic [2:0]      o_alu_control;
   logic [3:0]      o_ra_addr, o_rb_addr, o_rd_addr;
   logic            o_sel_imm;
   logic [N-1:0]    o_imm;
   logic            o_reg_we;
   logic [2:0]      o_flags;
   logic            o_halted;

   int checks = 0;
   int errors = 0;

   // Reference model state: program memory plus the architectural PC, flags and halt.
   logic [15:0] mem [256];
   int          m_pc;
   logic [2:0]  m_flags;
   bit          m_halt;
   logic [2:0]  alu_tab [7];

   always #5 i_clk = ~i_clk;

   alu_control_unit #(.N(N), .PC_W(PC_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .o_pc(o_pc), .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .i_instr(i_instr),
      .o_alu_control(o_alu_control), .o_ra_addr(o_ra_addr), .o_rb_addr(o_rb_addr),
      .o_rd_addr(o_rd_addr), .o_sel_imm(o_sel_imm), .o_imm(o_imm), .o_reg_we(o_reg_we),
      .i_mayor(i_mayor), .i_paridad(i_paridad), .i_zero(i_zero),
      .o_flags(o_flags), .o_halted(o_halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_start = 1'b0; i_imem_ack = 1'b0;
      {i_mayor, i_paridad, i_zero} = 3'b000;
      @(negedge i_clk); @(negedge i_clk);
      chk("rst_pc", o_pc, 0);
      chk("rst_req", o_imem_req, 0);
      chk("rst_we", o_reg_we, 0);
      chk("rst_alu", o_alu_control, 3'b101);
      chk("rst_sel_imm", o_sel_imm, 0);
      chk("rst_addr", {o_rd_addr, o_ra_addr, o_rb_addr}, 0);
      chk("rst_imm", o_imm, 0);
      chk("rst_flags", o_flags, 0);
      chk("rst_halted", o_halted, 0);
      i_rst_n = 1'b1;
      m_pc = 0; m_flags = 3'b000; m_halt = 1'b0;
      @(negedge i_clk);
      chk("idle_no_req", o_imem_req, 0);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   // Executes one instruction through the handshake and checks it against the ISA-level model.
   // dly < 0 picks a random ack delay. force_f forces the flag inputs seen in EXEC.
   // abort drops reset in the middle of EXEC.
   task automatic run_instr(input int dly, input bit force_f, input logic [2:0] ff, input bit abort);
      logic [15:0] ins;
      logic [3:0]  op;
      logic [2:0]  fl;
      bit          take;
      int          d;
      int          n;
      n = 0;
      while (!o_imem_req && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      chk("req_seen", o_imem_req, 1);
      ins = mem[m_pc];
      op  = ins[15:12];
      d   = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int k = 0; k < d; k++) begin
         i_imem_ack = 1'b0;
         i_instr    = N'($urandom);
         chk("wait_req", o_imem_req, 1);
         chk("wait_pc", o_pc, m_pc);
         chk("wait_we", o_reg_we, 0);
         @(negedge i_clk);
      end
      chk("fetch_pc", o_pc, m_pc);
      i_imem_ack = 1'b1;
      i_instr    = ins;
      @(negedge i_clk);
      // DECODE: a stray ack with a garbage word must be ignored.
      i_imem_ack = 1'($urandom_range(0, 1));
      i_instr    = N'($urandom);
      chk("dec_req", o_imem_req, 0);
      chk("dec_we", o_reg_we, 0);
      chk("dec_rd", o_rd_addr, ins[11:8]);
      chk("dec_ra", o_ra_addr, ins[7:4]);
      chk("dec_rb", o_rb_addr, ins[3:0]);
      chk("dec_imm", o_imm, {8'h00, ins[7:0]});
      if (op <= 4'd6) begin
         chk("dec_alu", o_alu_control, alu_tab[op]);
         chk("dec_sel_imm", o_sel_imm, (op == 4'd6));
      end
      @(negedge i_clk);
      // EXEC
      chk("exec_we", o_reg_we, (op <= 4'd6));
      chk("exec_rd", o_rd_addr, ins[11:8]);
      if (op <= 4'd6) chk("exec_alu", o_alu_control, alu_tab[op]);
      fl = force_f ? ff : 3'($urandom);
      {i_mayor, i_paridad, i_zero} = fl;
      if (abort) begin
         i_rst_n = 1'b0;
         #1;
         chk("abort_we", o_reg_we, 0);
         chk("abort_pc", o_pc, 0);
         chk("abort_req", o_imem_req, 0);
         m_pc = 0; m_flags = 3'b000;
      end else begin
         @(negedge i_clk);
         i_imem_ack = 1'b0;
         if (op <= 4'd6) begin
            m_flags = fl;
            m_pc = (m_pc + 1) % 256;
         end else if (op == 4'd7) begin
            m_pc = ins[7:0];
         end else if (op >= 4'd8 && op <= 4'd10) begin
            take = (op == 4'd8) ? m_flags[0] : (op == 4'd9) ? m_flags[2] : m_flags[1];
            m_pc = take ? int'(ins[7:0]) : (m_pc + 1) % 256;
         end else if (op == 4'd15) begin
            m_halt = 1'b1;
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
         chk("post_we", o_reg_we, 0);
         chk("post_pc", o_pc, m_pc);
         chk("post_flags", o_flags, m_flags);
         chk("post_halted", o_halted, m_halt);
         chk("post_req", o_imem_req, !m_halt);
      end
   endtask

   initial begin
      alu_tab = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b100};
      for (int a = 0; a < 256; a++) mem[a] = 16'hB000;

      // LDI r1,#0x05 ; HALT
      do_reset();
      mem[0] = 16'h6105; mem[1] = 16'hF000;
      pulse_start();
      run_instr(0, 1'b0, 3'b000, 1'b0);
      run_instr(0, 1'b0, 3'b000, 1'b0);
      chk("halt_flag", o_halted, 1);
      chk("halt_pc", o_pc, 1);
      i_start = 1'b1;
      repeat (4) @(negedge i_clk);
      i_start = 1'b0;
      chk("halt_hold_pc", o_pc, 1);
      chk("halt_hold_flag", o_halted, 1);
      chk("halt_no_req", o_imem_req, 0);

      // ADD setting mayor+zero, then JZ taken (with 4-cycle ack wait); then not taken.
      do_reset();
      mem[0] = 16'h0123; mem[1] = 16'h8020; mem[8'h20] = 16'h0456; mem[8'h21] = 16'h8020;
      pulse_start();
      run_instr(-1, 1'b1, 3'b101, 1'b0);
      chk("flags_after_add", o_flags, 3'b101);
      run_instr(4, 1'b1, 3'b000, 1'b0);
      chk("jz_taken_pc", o_pc, 8'h20);
      run_instr(-1, 1'b1, 3'b100, 1'b0);
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      chk("jz_not_taken_pc", o_pc, 8'h22);

      // PC wrap from 0xFF, then JMP 0x3C keeps flags.
      do_reset();
      for (int a = 0; a < 256; a++) mem[a] = 16'hB000;
      mem[0] = 16'h0789; mem[1] = 16'h70FF; mem[255] = 16'hC000;
      pulse_start();
      run_instr(-1, 1'b1, 3'b110, 1'b0);
      mem[0] = 16'h703C;
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      chk("jmp_ff_pc", o_pc, 8'hFF);
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      chk("wrap_pc", o_pc, 8'h00);
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      chk("jmp_3c_pc", o_pc, 8'h3C);
      chk("jmp_flags", o_flags, 3'b110);

      // Reset dropped during EXEC of SUB.
      do_reset();
      mem[0] = 16'hB000; mem[1] = 16'hC000; mem[2] = 16'h1234;
      pulse_start();
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      run_instr(-1, 1'b0, 3'b000, 1'b0);
      run_instr(0, 1'b0, 3'b000, 1'b1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         chk("abort_no_fetch", o_imem_req, 0);
      end

      // Opcode sweep 0..6 and B..E, then a random program (no HALT).
      do_reset();
      for (int a = 0; a < 256; a++) mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
      for (int a = 0; a < 7; a++) mem[a][15:12] = 4'(a);
      for (int a = 0; a < 4; a++) mem[7 + a][15:12] = 4'(11 + a);
      pulse_start();
      for (int s = 0; s < 80; s++) run_instr(-1, 1'b0, 3'b000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
